ram_1024x64_arbiter: RTL and testbench
======================================

// Module: ram_1024x64_arbiter
// PURPOSE
//  Shares one single-port 1024x64 byte-writable SRAM between two requesters:
//  I (instruction fetch, read-only) and D (data, read/write with byte enables).
//  One access per cycle, round-robin on conflict. An optional post-reset zero-fill
//  sequence clears the RAM before any requester is served. Sits between the CPU
//  fetch/LSU ports and the RAM macro; drives the macro pins directly.
// PARAMETERS
//  AW         10  address width (words); depth = 2**AW
//  NB         8   byte lanes; data width DW = 8*NB
//  INIT_ZERO  1   1: zero-fill all 2**AW words after reset; 0: serve requests immediately
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RESETn     in   1   asynchronous active-low reset
//  i_req      in   1   I access request (read)
//  i_addr     in   AW  I word address
//  i_gnt      out  1   I request accepted this cycle (combinational)
//  i_rvalid   out  1   I read data valid (cycle after grant)
//  i_rdata    out  DW  I read data
//  d_req      in   1   D access request
//  d_we       in   NB  D byte write enables; all-zero = read
//  d_addr     in   AW  D word address
//  d_wdata    in   DW  D write data
//  d_gnt      out  1   D request accepted this cycle (combinational)
//  d_rvalid   out  1   D read data valid (cycle after a read grant)
//  d_rdata    out  DW  D read data
//  init_done  out  1   zero-fill complete, requests now served
//  ram_EN     out  1   RAM enable
//  ram_WE     out  NB  RAM byte write enables
//  ram_A      out  AW  RAM address
//  ram_Di     out  DW  RAM write data
//  ram_Do     in   DW  RAM read data (valid one cycle after EN with WE==0)
// BEHAVIOUR
//  States: CLEAR, RUN. Reset -> CLEAR if INIT_ZERO=1, else RUN.
//  Reset values: i_rvalid=d_rvalid=0, clr_cnt=0, last_gnt=D, init_done=~INIT_ZERO.
//  While RESETn low: i_gnt=d_gnt=0, ram_EN=0, ram_WE=0 regardless of inputs.
//  CLEAR: ram_EN=1, ram_WE=all ones, ram_Di=0, ram_A=clr_cnt; clr_cnt++ each cycle;
//   i_gnt=d_gnt=0. When clr_cnt==2**AW-1, the write is issued and the FSM moves to RUN;
//   init_done=1 from the next cycle. Exactly 2**AW clear cycles; reset mid-clear restarts at 0.
//  RUN arbitration (combinational, same cycle):
//   only i_req -> I; only d_req -> D; both -> the port not equal to last_gnt.
//   last_gnt <= winner on each grant; unchanged when idle.
//  RUN RAM drive: winner I: EN=1, WE=0, A=i_addr. Winner D: EN=1, WE=d_we,
//   A=d_addr, Di=d_wdata. No request: EN=0, WE=0 (A/Di don't-care, held at D values).
//  Requester holds req/addr/data until gnt; a request not granted is simply retried.
//  Read latency 1: i_rvalid <= i_gnt; d_rvalid <= d_gnt & (d_we==0).
//   i_rdata=d_rdata=ram_Do (pass-through); meaningful only while the matching rvalid=1.
//   D writes produce no rvalid; a write is complete at its grant edge.
//  Back-to-back: a new grant is allowed in the same cycle as the previous rvalid.
//   D read after D write to the same address in consecutive cycles returns new data.
//  Fairness: with both requesting continuously, grants alternate; no starvation beyond 1 cycle.
// TESTING
//  T1 INIT_ZERO=1: pre-load RAM junk, reset, hold i_req=1 -> no gnt for 1024 cycles,
//     init_done rises at cycle 1025; read addr 0x3FF -> 0.
//  T2 d_req write 0x3A5 d_we=0xFF d_wdata=64'h0123_4567_89AB_CDEF, then I read 0x3A5
//     -> i_rvalid next cycle, i_rdata=64'h0123_4567_89AB_CDEF.
//  T3 D write d_we=8'h0F wdata=all F to a zeroed word, D read -> 64'h0000_0000_FFFF_FFFF.
//  T4 i_req,d_req both held 1 for 8 cycles after reset -> grants I,D,I,D,...; each 4 grants;
//     rvalid pulses one cycle after each respective read grant.
//  T5 assert RESETn=0 at clear count 500 -> ram_EN=0 immediately; on release, clearing
//     restarts at addr 0, init_done after a full 1024 cycles.
//  T6 INIT_ZERO=0: first cycle after reset, d_req read -> d_gnt=1 same cycle, init_done=1.

Source files
------------

// File: rtl/ram_1024x64_arbiter.sv
// ram_1024x64_arbiter
//   Shares one single-port byte-writable SRAM macro between an instruction-fetch
//   requester (I, read-only) and a data requester (D, read/write with byte enables).
//   One access per cycle; round-robin when both request in the same cycle.
//   With INIT_ZERO=1 the whole array is cleared after reset before any request is served.
// Ports
//   CLK, RESETn               clock, asynchronous active-low reset
//   i_req/i_addr/i_gnt        I request, word address, combinational grant
//   i_rvalid/i_rdata          I read data, one cycle after grant
//   d_req/d_we/d_addr/d_wdata D request; d_we all-zero means read
//   d_gnt/d_rvalid/d_rdata    D grant (combinational), read data one cycle after read grant
//   init_done                 zero-fill finished, requests are being served
//   ram_EN/WE/A/Di/Do         SRAM macro pins
module ram_1024x64_arbiter #(
   parameter int unsigned AW        = 10,
   parameter int unsigned NB        = 8,
   parameter int unsigned INIT_ZERO = 1
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              i_req,
   input  logic [AW-1:0]     i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [8*NB-1:0]   i_rdata,
   input  logic              d_req,
   input  logic [NB-1:0]     d_we,
   input  logic [AW-1:0]     d_addr,
   input  logic [8*NB-1:0]   d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [8*NB-1:0]   d_rdata,
   output logic              init_done,
   output logic              ram_EN,
   output logic [NB-1:0]     ram_WE,
   output logic [AW-1:0]     ram_A,
   output logic [8*NB-1:0]   ram_Di,
   input  logic [8*NB-1:0]   ram_Do
);

   localparam logic [AW-1:0] CLR_LAST = AW'((2**AW) - 1);

   typedef enum logic {S_CLEAR, S_RUN} state_t;

   state_t          state;
   logic [AW-1:0]   clr_cnt;
   logic            last_d;   // 1: most recent grant went to D

   // Read data is a straight pass-through of the macro output
   assign i_rdata = ram_Do;
   assign d_rdata = ram_Do;

   // Arbitration and macro pin drive; everything is forced idle while in reset
   always_comb begin
      i_gnt  = 1'b0;
      d_gnt  = 1'b0;
      ram_EN = 1'b0;
      ram_WE = '0;
      ram_A  = d_addr;
      ram_Di = d_wdata;
      if (RESETn) begin
         if (state == S_CLEAR) begin
            ram_EN = 1'b1;
            ram_WE = '1;
            ram_A  = clr_cnt;
            ram_Di = '0;
         end else begin
            // On conflict the port that did not win last time goes first
            i_gnt = i_req & (~d_req | last_d);
            d_gnt = d_req & ~i_gnt;
            if (i_gnt) begin
               ram_EN = 1'b1;
               ram_A  = i_addr;
            end else if (d_gnt) begin
               ram_EN = 1'b1;
               ram_WE = d_we;
            end
         end
      end
   end

   // Clear sequencer, round-robin history and read-valid pipeline
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state     <= (INIT_ZERO != 0) ? S_CLEAR : S_RUN;
         clr_cnt   <= '0;
         last_d    <= 1'b1;
         init_done <= (INIT_ZERO == 0);
         i_rvalid  <= 1'b0;
         d_rvalid  <= 1'b0;
      end else begin
         i_rvalid <= i_gnt;
         d_rvalid <= d_gnt & (d_we == '0);
         if (i_gnt) begin
            last_d <= 1'b0;
         end else if (d_gnt) begin
            last_d <= 1'b1;
         end
         if (state == S_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == CLR_LAST) begin
               state     <= S_RUN;
               init_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_1024x64_arbiter.sv
// tb_ram_1024x64_arbiter
//   Two arbiter instances (INIT_ZERO=1 and INIT_ZERO=0), each with its own SRAM
//   macro model. Inputs are shared; sel picks which instance is being checked.
//   A transaction-level reference (expected memory contents, last winner)
//   predicts grants, macro pin drive, rvalid and read data.
module tb_ram_1024x64_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        junk;
   logic        i_req, d_req;
   logic [9:0]  i_addr, d_addr;
   logic [7:0]  d_we;
   logic [63:0] d_wdata;

   logic        i_gnt [2], i_rvalid [2], d_gnt [2], d_rvalid [2], init_done [2], ram_en [2];
   logic [63:0] i_rdata [2], d_rdata [2], ram_di [2], ram_do [2];
   logic [7:0]  ram_we [2];
   logic [9:0]  ram_a [2];

   for (genvar g = 0; g < 2; g++) begin : g_inst
      logic [63:0] mem [1024];

      ram_1024x64_arbiter #(.AW(10), .NB(8), .INIT_ZERO((g == 0) ? 1 : 0)) dut (
         .CLK(clk), .RESETn(rst_n[g]),
         .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[g]),
         .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
         .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
         .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
         .init_done(init_done[g]),
         .ram_EN(ram_en[g]), .ram_WE(ram_we[g]), .ram_A(ram_a[g]),
         .ram_Di(ram_di[g]), .ram_Do(ram_do[g])
      );

      // Single-port SRAM macro: read data appears one cycle after EN with WE==0
      always @(posedge clk) begin
         if (junk) begin
            for (int k = 0; k < 1024; k++) mem[k] <= {$urandom, $urandom};
         end else if (ram_en[g]) begin
            if (ram_we[g] == 8'h00) ram_do[g] <= mem[ram_a[g]];
            else for (int b = 0; b < 8; b++)
               if (ram_we[g][b]) mem[ram_a[g]][8*b +: 8] <= ram_di[g][8*b +: 8];
         end
      end
   end

   int          total = 0;
   int          passed = 0;
   int          sel = 0;
   logic [63:0] ref_mem [1024];
   bit          ref_ok [1024];
   bit          exp_last_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [9:0] pick_addr();
      if ($urandom_range(0, 3) == 0) return 10'($urandom);
      return 10'($urandom_range(0, 7));
   endfunction

   // One RUN-state cycle: called at a falling edge, returns at the next falling edge
   task automatic cycle(input bit ir, input logic [9:0] ia, input bit dr, input logic [7:0] dw,
                        input logic [9:0] da, input logic [63:0] dd, output bit gi, output bit gd);
      bit          egi, egd, erd_ok;
      logic [63:0] erd;
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
      #1;
      egi = ir && (!dr || exp_last_d);
      egd = dr && !egi;
      gi = i_gnt[sel];
      gd = d_gnt[sel];
      chk("i_gnt", 64'(i_gnt[sel]), 64'(egi));
      chk("d_gnt", 64'(d_gnt[sel]), 64'(egd));
      chk("ram_en", 64'(ram_en[sel]), 64'(egi || egd));
      erd = '0; erd_ok = 1'b0;
      if (egi) begin
         chk("ram_a_i", 64'(ram_a[sel]), 64'(ia));
         chk("ram_we_i", 64'(ram_we[sel]), 64'h0);
         erd = ref_mem[ia]; erd_ok = ref_ok[ia];
         exp_last_d = 1'b0;
      end else if (egd) begin
         chk("ram_a_d", 64'(ram_a[sel]), 64'(da));
         chk("ram_we_d", 64'(ram_we[sel]), 64'(dw));
         if (dw != 8'h00) begin
            chk("ram_di", ram_di[sel], dd);
            for (int b = 0; b < 8; b++) if (dw[b]) ref_mem[da][8*b +: 8] = dd[8*b +: 8];
            if (dw == 8'hFF) ref_ok[da] = 1'b1;
         end else begin
            erd = ref_mem[da]; erd_ok = ref_ok[da];
         end
         exp_last_d = 1'b1;
      end else begin
         chk("ram_we_idle", 64'(ram_we[sel]), 64'h0);
      end
      @(posedge clk); #1;
      chk("i_rvalid", 64'(i_rvalid[sel]), 64'(egi));
      chk("d_rvalid", 64'(d_rvalid[sel]), 64'(egd && dw == 8'h00));
      if (egi && erd_ok) chk("i_rdata", i_rdata[sel], erd);
      if (egd && dw == 8'h00 && erd_ok) chk("d_rdata", d_rdata[sel], erd);
      @(negedge clk);
   endtask

   task automatic random_run(input int n);
      bit ip = 0, dp = 0, gi, gd;
      logic [9:0]  ia = '0, da = '0;
      logic [7:0]  dw = '0;
      logic [63:0] dd = '0;
      for (int t = 0; t < n; t++) begin
         // A request that was not granted is held unchanged
         if (!ip) begin ip = 1'($urandom_range(0, 1)); ia = pick_addr(); end
         if (!dp) begin
            dp = 1'($urandom_range(0, 1)); da = pick_addr(); dd = {$urandom, $urandom};
            case ($urandom_range(0, 2))
               0:       dw = 8'h00;
               1:       dw = 8'hFF;
               default: dw = 8'($urandom);
            endcase
         end
         cycle(ip, ia, dp, dw, da, dd, gi, gd);
         if (gi) ip = 0;
         if (gd) dp = 0;
      end
   endtask

   initial begin
      bit gi, gd;
      int ni, nd;
      rst_n[0] = 1'b0; rst_n[1] = 1'b0; junk = 1'b0;
      i_req = 1'b1; i_addr = 10'h3FF; d_req = 1'b1; d_we = 8'h00; d_addr = '0; d_wdata = '0;

      // Fill both macros with junk while held in reset
      @(negedge clk); junk = 1'b1;
      @(negedge clk); junk = 1'b0;
      #1;
      chk("rst_en", 64'(ram_en[0]), 64'h0);
      chk("rst_we", 64'(ram_we[0]), 64'h0);
      chk("rst_gnt", 64'({i_gnt[0], d_gnt[0]}), 64'h0);
      chk("rst_rvalid", 64'({i_rvalid[0], d_rvalid[0]}), 64'h0);
      chk("rst_init_done", 64'(init_done[0]), 64'h0);

      // Start clearing, then reset again at count 500
      d_req = 1'b0;
      @(negedge clk); rst_n[0] = 1'b1;
      for (int k = 0; k < 500; k++) begin
         #1;
         chk("clr1_a", 64'(ram_a[0]), 64'(k));
         @(negedge clk);
      end
      rst_n[0] = 1'b0;
      #1;
      chk("midrst_en", 64'(ram_en[0]), 64'h0);
      chk("midrst_we", 64'(ram_we[0]), 64'h0);

      // Full clear from address 0 with I requesting all along
      @(negedge clk); rst_n[0] = 1'b1;
      for (int k = 0; k < 1024; k++) begin
         #1;
         chk("clr_a", 64'(ram_a[0]), 64'(k));
         chk("clr_pins", 64'({ram_en[0], ram_we[0], i_gnt[0], d_gnt[0], init_done[0]}),
             64'({1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}));
         chk("clr_di", ram_di[0], 64'h0);
         @(negedge clk);
      end
      chk("init_done_rise", 64'(init_done[0]), 64'h1);

      for (int k = 0; k < 1024; k++) begin ref_mem[k] = '0; ref_ok[k] = 1'b1; end
      exp_last_d = 1'b1;
      cycle(1'b1, 10'h3FF, 1'b0, 8'h00, 10'h0, 64'h0, gi, gd);
      chk("read_3ff", i_rdata[0], 64'h0);

      // D full write, then I read back
      cycle(1'b0, 10'h0, 1'b1, 8'hFF, 10'h3A5, 64'h0123_4567_89AB_CDEF, gi, gd);
      cycle(1'b1, 10'h3A5, 1'b0, 8'h00, 10'h0, 64'h0, gi, gd);
      chk("i_read_3a5", i_rdata[0], 64'h0123_4567_89AB_CDEF);

      // Partial write to a zeroed word, read back in the very next cycle
      cycle(1'b0, 10'h0, 1'b1, 8'h0F, 10'h010, 64'hFFFF_FFFF_FFFF_FFFF, gi, gd);
      cycle(1'b0, 10'h0, 1'b1, 8'h00, 10'h010, 64'h0, gi, gd);
      chk("d_read_partial", d_rdata[0], 64'h0000_0000_FFFF_FFFF);

      random_run(400);

      // INIT_ZERO=0 instance: ready straight out of reset
      rst_n[0] = 1'b0; sel = 1;
      i_req = 1'b0; d_req = 1'b1; d_we = 8'h00;
      #1;
      chk("nz_rst_init_done", 64'(init_done[1]), 64'h1);
      chk("nz_rst_d_gnt", 64'(d_gnt[1]), 64'h0);
      @(negedge clk); rst_n[1] = 1'b1;
      for (int k = 0; k < 1024; k++) ref_ok[k] = 1'b0;
      exp_last_d = 1'b1;
      cycle(1'b0, 10'h0, 1'b1, 8'h00, 10'h005, 64'h0, gi, gd);
      chk("nz_init_done", 64'(init_done[1]), 64'h1);

      // Reset clears a pending rvalid; then both requesting for 8 cycles
      cycle(1'b0, 10'h0, 1'b1, 8'h00, 10'h006, 64'h0, gi, gd);
      rst_n[1] = 1'b0;
      #1;
      chk("nz_rst_rvalid", 64'({i_rvalid[1], d_rvalid[1]}), 64'h0);
      @(negedge clk); rst_n[1] = 1'b1;
      exp_last_d = 1'b1;
      ni = 0; nd = 0;
      for (int t = 0; t < 8; t++) begin
         cycle(1'b1, 10'(t), 1'b1, 8'h00, 10'(t + 100), 64'h0, gi, gd);
         ni += int'(gi); nd += int'(gd);
      end
      chk("fair_i_count", 64'(ni), 64'd4);
      chk("fair_d_count", 64'(nd), 64'd4);

      random_run(150);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
